// File: rtl/imm_pkg.sv
// Shared definitions for the immediate encoder: format codes, the fallback
// NOP word and a range helper used by the packer.
package imm_pkg;

    localparam logic [2:0]  IMM_I = 3'b000;
    localparam logic [2:0]  IMM_S = 3'b001;
    localparam logic [2:0]  IMM_B = 3'b010;
    localparam logic [2:0]  IMM_U = 3'b011;
    localparam logic [2:0]  IMM_J = 3'b100;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_I = IMM_I,
        FMT_S = IMM_S,
        FMT_B = IMM_B,
        FMT_U = IMM_U,
        FMT_J = IMM_J
    } imm_fmt_e;

    // True when v[31:lsb] are all equal, i.e. v sign-extends from bit lsb.
    function automatic logic upper_uniform(input logic [31:0] v, input int lsb);
        logic all_ones;
        logic all_zeros;
        all_ones  = 1'b1;
        all_zeros = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i >= lsb) begin
                all_ones  = all_ones & v[i];
                all_zeros = all_zeros & ~v[i];
            end
        end
        return all_ones | all_zeros;
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational scatter of an immediate into the RISC-V I/S/B/U/J bit
// positions of a base instruction, with a representability check.
module imm_pack
    import imm_pkg::*;
#(
    parameter bit PASS_ILLEGAL = 1'b1
) (
    input  logic [31:0] imm_i,
    input  logic [2:0]  sel_i,
    input  logic [31:0] base_i,
    output logic [31:0] word_o,
    output logic        err_o
);

    imm_fmt_e fmt;
    assign fmt = imm_fmt_e'(sel_i);

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        word_o = base_i;
        err_o  = 1'b0;
        case (fmt)
            FMT_I: begin
                word_o[31:20] = imm_i[11:0];
                err_o         = !upper_uniform(imm_i, 11);
            end
            FMT_S: begin
                word_o[31:25] = imm_i[11:5];
                word_o[11:7]  = imm_i[4:0];
                err_o         = !upper_uniform(imm_i, 11);
            end
            FMT_B: begin
                word_o[31]    = imm_i[12];
                word_o[30:25] = imm_i[10:5];
                word_o[11:8]  = imm_i[4:1];
                word_o[7]     = imm_i[11];
                err_o         = !upper_uniform(imm_i, 12) || imm_i[0];
            end
            FMT_U: begin
                word_o[31:12] = imm_i[31:12];
                err_o         = |imm_i[11:0];
            end
            FMT_J: begin
                word_o[31]    = imm_i[20];
                word_o[30:21] = imm_i[10:1];
                word_o[20]    = imm_i[11];
                word_o[19:12] = imm_i[19:12];
                err_o         = !upper_uniform(imm_i, 20) || imm_i[0];
            end
            default: begin
                word_o = PASS_ILLEGAL ? base_i : NOP_INSTR;
                err_o  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: packer followed by a two-stage valid/ready pipeline
// and a saturating count of errored words delivered downstream.
module imm_encoder
    import imm_pkg::*;
#(
    parameter int unsigned ERR_CNT_W    = 16,
    parameter bit          PASS_ILLEGAL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [31:0]          BaseInstr,
    input  logic [31:0]          Imm,
    input  logic [2:0]           ImmSel,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [31:0]          Instr,
    output logic                 ImmErr,
    output logic [ERR_CNT_W-1:0] ErrCount,
    input  logic                 ClrErr
);

    logic [31:0] pack_word;
    logic        pack_err;

    imm_pack #(.PASS_ILLEGAL(PASS_ILLEGAL)) u_pack (
        .imm_i  (Imm),
        .sel_i  (ImmSel),
        .base_i (BaseInstr),
        .word_o (pack_word),
        .err_o  (pack_err)
    );

    logic                 s1_valid_q, s1_valid_d;
    logic [31:0]          s1_instr_q, s1_instr_d;
    logic                 s1_err_q,   s1_err_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [31:0]          s2_instr_q, s2_instr_d;
    logic                 s2_err_q,   s2_err_d;
    logic [ERR_CNT_W-1:0] cnt_q,      cnt_d;

    logic s2_adv;
    logic s1_en;

    // s1 may also fill while s2 is stalled, as long as s1 itself is empty.
    assign s2_adv  = !s2_valid_q || OutReady;
    assign s1_en   = s2_adv || !s1_valid_q;
    assign InReady = s1_en;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_instr_d = s1_instr_q;
        s1_err_d   = s1_err_q;
        s2_valid_d = s2_valid_q;
        s2_instr_d = s2_instr_q;
        s2_err_d   = s2_err_q;
        cnt_d      = cnt_q;

        if (s1_en) begin
            s1_valid_d = InValid;
            if (InValid) begin
                s1_instr_d = pack_word;
                s1_err_d   = pack_err;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_instr_d = s1_instr_q;
                s2_err_d   = s1_err_q;
            end
        end

        if (ClrErr) begin
            cnt_d = '0;
        end else if (s2_valid_q && OutReady && s2_err_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + ERR_CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_instr_q <= '0;
            s1_err_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_instr_q <= s1_instr_d;
            s1_err_q   <= s1_err_d;
            s2_valid_q <= s2_valid_d;
            s2_instr_q <= s2_instr_d;
            s2_err_q   <= s2_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign OutValid = s2_valid_q;
    assign Instr    = s2_instr_q;
    assign ImmErr   = s2_err_q;
    assign ErrCount = cnt_q;

endmodule
